apb_master_module: RTL and testbench
====================================

# apb_master_module

Requester (initiator) side of the 8-bit APB link: accepts single read/write commands on a valid/ready request port, runs the APB SETUP/ACCESS sequence toward one completer, and returns read data and error status on a one-cycle response pulse. Sits between a local controller (register-config sequencer or bus bridge) and the existing APB completer interface, driving its psel_x/penable/paddr/pwrite/pwdata and sampling its pready/prdata/pslverr.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS wait cycles with pready low before abort (used only with APB_MASTER_TIMEOUT_EN).
- pclk  in  1  clock; all logic rises on pclk.
- preset  in  1  synchronous reset, active-high (one clock; reset synchronous, active-high).
- req_valid  in  1  command present.
- req_ready  out  1  command accepted this cycle when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  3  target register address.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  8  read data (0 for writes and aborted transfers).
- rsp_err  out  1  pslverr sampled at completion, or timeout abort.
- psel_x  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  3  APB address.
- pwdata  out  8  APB write data.
- pready  in  1  completer ready.
- prdata  in  8  completer read data.
- pslverr  in  1  completer error.

## Operation
- FSM states IDLE, SETUP, ACCESS; encoding from shared package.
- IDLE: req_ready=1; on handshake latch write/addr/wdata into paddr/pwrite/pwdata, go SETUP. Otherwise stay.
- SETUP: psel_x=1, penable=0; unconditionally go ACCESS next cycle.
- ACCESS: psel_x=1, penable=1; paddr/pwrite/pwdata held stable. pready=0 → stay. pready=1 → complete: register rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, pulse rsp_valid next cycle.
- Back-to-back: req_ready=1 also in the ACCESS cycle where pready=1; handshake there → next state SETUP with new command (psel_x stays high, penable drops). No handshake → IDLE, psel_x=0.
- req_ready=0 in SETUP and in ACCESS while pready=0.
- pslverr and prdata ignored except in the completing ACCESS cycle.
- Response port has no backpressure; consumer must accept every pulse.

## Timing
- Reset values: state IDLE, psel_x=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 in the first cycle after reset.
- All APB and response outputs registered; req_ready combinational from state and pready.
- Zero-wait transfer: handshake at edge N, SETUP cycle N+1, ACCESS cycle N+2 (pready=1), rsp_valid high cycle N+3. Each pready=0 cycle adds one.
- Back-to-back throughput: one transfer per 2 cycles with zero wait states.
- preset mid-transfer: at the next edge all outputs return to reset values; no rsp_valid for the killed transfer; command discarded.
- preset and req_valid together: reset wins, command not accepted.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter clears on SETUP entry, increments each ACCESS cycle with pready=0; reaching TIMEOUT_CYCLES with pready still 0 aborts: next state IDLE, psel_x/penable=0, rsp_valid pulse with rsp_err=1, rsp_rdata=0. pready=1 in the same cycle as expiry completes normally (pready wins).
- Undefined: no counter, ACCESS waits indefinitely, TIMEOUT_CYCLES unused.

## Structure
- Shared package apb_pkg: ADDR_W=3, DATA_W=8, state enum apb_state_t {IDLE, SETUP, ACCESS}, request struct (write, addr, wdata).
- One sub-module: apb_timeout_counter (clear, count-enable, expired), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x5A to addr 1, pready=1 immediately → psel_x rises N+1, penable N+2 with paddr=1, pwdata=0x5A, pwrite=1; rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read addr 3, pready low 3 cycles then high with prdata=0xC3 → ACCESS held 4 cycles, signals stable; rsp_valid with rsp_rdata=0xC3.
- Read addr 7 with pslverr=1 at completion → rsp_err=1, rsp_rdata=prdata value.
- Two commands back-to-back (write 0x11 addr 0, read addr 2) → psel_x continuous, penable low one cycle between, two rsp_valid pulses 2 cycles apart.
- preset asserted in ACCESS with pready=0 → psel_x/penable=0 next edge, no rsp_valid, req_ready=1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 → abort after 4 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the 8-bit APB link: bus widths, requester FSM states and
// the latched command record.
package apb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles spent waiting on pready; flags expiry on the wait cycle
// that brings the count to LIMIT. Used only when APB_MASTER_TIMEOUT_EN is defined.
module apb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign expired = count_en && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge pclk) begin
    if (preset || clear) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_module.sv
// APB requester: one valid/ready command in, SETUP/ACCESS toward a completer,
// one-cycle response pulse out. Optional ACCESS timeout via APB_MASTER_TIMEOUT_EN.
module apb_master_module
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel_x,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  apb_state_t state_q, state_d;
  apb_req_t   req;
  logic       handshake;
  logic       complete;
  logic       abort;

  assign req       = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign complete  = (state_q == ACCESS) && pready;
  // The completing ACCESS cycle can already take the next command.
  assign req_ready = (state_q == IDLE) || complete;
  assign handshake = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_expired;

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (state_q == SETUP),
    .count_en((state_q == ACCESS) && !pready),
    .expired (tmo_expired)
  );

  assign abort = tmo_expired;
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (complete)   state_d = handshake ? SETUP : IDLE;
        else if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      psel_x    <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_x    <= (state_d != IDLE);
      penable   <= (state_d == ACCESS);
      rsp_valid <= complete || abort;
      if (handshake) begin
        pwrite <= req.write;
        paddr  <= req.addr;
        pwdata <= req.wdata;
      end
      if (complete) begin
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= pslverr;
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_module.sv
// Self-checking bench for apb_master_module: a timestamp-based transaction
// model predicts every output each cycle; directed literal checks pin the model.
module tb_apb_master_module;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int          NEVER      = 1 << 30;

  logic       pclk = 1'b0;
  logic       preset;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel_x, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic       pready  = 1'b0;
  logic [7:0] prdata  = 8'h00;
  logic       pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_module #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel_x   (psel_x),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  // One accepted command: s = SETUP cycle, alen = number of ACCESS cycles,
  // kill = first cycle after a reset that discarded it.
  typedef struct {
    int         s;
    int         alen;
    bit         write;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
    bit         timeout;
    int         kill;
  } txn_t;

  txn_t txns[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  bit   check_en = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Completer: pready low through the wait cycles, high with data on the
  // completing ACCESS cycle, random junk everywhere else.
  always @(posedge pclk) begin
    #1;
    pready  = 1'($urandom_range(0, 1));
    prdata  = 8'($urandom);
    pslverr = 1'($urandom);
    foreach (txns[i]) begin
      if (cyc >= txns[i].kill) continue;
      if (cyc >= txns[i].s + 1 && cyc <= txns[i].s + txns[i].alen) begin
        if (cyc == txns[i].s + txns[i].alen && !txns[i].timeout) begin
          pready  = 1'b1;
          prdata  = txns[i].rdata;
          pslverr = txns[i].err;
        end else begin
          pready = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the transaction model.
  always @(negedge pclk) begin
    bit         e_psel, e_pen, e_rdy, e_rv, e_err, have_cmd;
    logic [7:0] e_rd, e_wd;
    logic [2:0] e_addr;
    bit         e_wr;
    int         c, last;
    if (check_en) begin
      c = cyc;
      e_psel = 0; e_pen = 0; e_rdy = 1; e_rv = 0; e_err = 0; have_cmd = 0;
      e_rd = '0; e_wd = '0; e_addr = '0; e_wr = 0;
      foreach (txns[i]) begin
        if (c >= txns[i].kill) continue;
        last = txns[i].s + txns[i].alen;
        if (c >= txns[i].s && c <= last) begin
          e_psel   = 1;
          have_cmd = 1;
          e_addr   = txns[i].addr;
          e_wr     = txns[i].write;
          e_wd     = txns[i].wdata;
          if (c >= txns[i].s + 1) e_pen = 1;
        end
        if (c >= txns[i].s && c < last) e_rdy = 0;
        if (c == last && txns[i].timeout) e_rdy = 0;
        if (c == last + 1) begin
          e_rv  = 1;
          e_rd  = (txns[i].write || txns[i].timeout) ? 8'h00 : txns[i].rdata;
          e_err = txns[i].timeout ? 1'b1 : txns[i].err;
        end
      end
      check("psel_x", psel_x, e_psel);
      check("penable", penable, e_pen);
      check("req_ready", req_ready, e_rdy);
      check("rsp_valid", rsp_valid, e_rv);
      if (have_cmd) begin
        check("paddr", paddr, e_addr);
        check("pwrite", pwrite, e_wr);
        check("pwdata", pwdata, e_wd);
      end
      if (e_rv) begin
        check("rsp_rdata", rsp_rdata, e_rd);
        check("rsp_err", rsp_err, e_err);
      end
    end
  end

  // Presents one command for one cycle; caller guarantees req_ready is due.
  task automatic issue(bit wr, logic [2:0] a, logic [7:0] wd, int waits,
                       logic [7:0] rd, bit er, bit tmo);
    txn_t t;
    t.s       = cyc + 1;
    t.alen    = tmo ? TB_TIMEOUT : waits + 1;
    t.write   = wr;
    t.addr    = a;
    t.wdata   = wd;
    t.rdata   = rd;
    t.err     = er;
    t.timeout = tmo;
    t.kill    = NEVER;
    txns.push_back(t);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    step(1);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 3'($urandom);
    req_wdata = 8'($urandom);
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    step(2);
    check("rst_psel_x", psel_x, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    preset   = 1'b0;
    check_en = 1'b1;
    step(1);

    // Zero-wait write 0x5A to addr 1.
    issue(1, 3'd1, 8'h5A, 0, 8'h00, 0, 0);
    check("t1_setup_psel", psel_x, 1);
    check("t1_setup_penable", penable, 0);
    step(1);
    check("t1_access_penable", penable, 1);
    check("t1_paddr", paddr, 3'd1);
    check("t1_pwdata", pwdata, 8'h5A);
    check("t1_pwrite", pwrite, 1);
    step(1);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_rsp_rdata", rsp_rdata, 8'h00);
    step(1);

    // Read addr 3 with three wait states.
    issue(0, 3'd3, 8'hFF, 3, 8'hC3, 0, 0);
    step(5);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 8'hC3);
    step(1);

    // Read addr 7 completing with pslverr.
    issue(0, 3'd7, 8'h00, 0, 8'h9E, 1, 0);
    step(2);
    check("t3_rsp_err", rsp_err, 1);
    check("t3_rsp_rdata", rsp_rdata, 8'h9E);
    step(1);

    // Back-to-back: write 0x11 addr 0, then read addr 2.
    issue(1, 3'd0, 8'h11, 0, 8'h00, 0, 0);
    step(1);
    issue(0, 3'd2, 8'h00, 0, 8'h4D, 0, 0);
    check("t4_gap_psel", psel_x, 1);
    check("t4_gap_penable", penable, 0);
    check("t4_gap_paddr", paddr, 3'd2);
    check("t4_first_rsp", rsp_valid, 1);
    step(2);
    check("t4_second_rsp", rsp_valid, 1);
    check("t4_second_rdata", rsp_rdata, 8'h4D);
    step(1);

    // Back-to-back with wait states on both transfers.
    issue(1, 3'd6, 8'hE7, 2, 8'h00, 0, 0);
    step(3);
    issue(0, 3'd5, 8'h00, 1, 8'h3C, 0, 0);
    step(3);
    step(1);

    // Reset while stuck in ACCESS: transfer is discarded.
    issue(0, 3'd5, 8'h00, 6, 8'h77, 0, 0);
    step(2);
    preset = 1'b1;
    txns[txns.size()-1].kill = cyc + 1;
    step(1);
    preset = 1'b0;
    check("t5_psel", psel_x, 0);
    check("t5_penable", penable, 0);
    check("t5_req_ready", req_ready, 1);
    check("t5_rsp_valid", rsp_valid, 0);
    step(8);

    // Reset together with a request: not accepted.
    preset    = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd4;
    req_wdata = 8'hAA;
    step(1);
    preset    = 1'b0;
    req_valid = 1'b0;
    check("t6_psel", psel_x, 0);
    step(3);
    check("t6_psel_later", psel_x, 0);

    // Wait count one short of the timeout limit still completes normally.
    issue(0, 3'd6, 8'h00, TB_TIMEOUT - 1, 8'hA5, 0, 0);
    step(TB_TIMEOUT + 1);
    check("t7_rsp_valid", rsp_valid, 1);
    check("t7_rsp_rdata", rsp_rdata, 8'hA5);
    check("t7_rsp_err", rsp_err, 0);
    step(1);

`ifdef APB_MASTER_TIMEOUT_EN
    // pready stuck low: abort after TB_TIMEOUT ACCESS cycles.
    issue(0, 3'd4, 8'h00, 0, 8'h00, 0, 1);
    step(TB_TIMEOUT);
    check("t8_last_access_ready", req_ready, 0);
    step(1);
    check("t8_rsp_valid", rsp_valid, 1);
    check("t8_rsp_err", rsp_err, 1);
    check("t8_rsp_rdata", rsp_rdata, 8'h00);
    check("t8_psel", psel_x, 0);
    step(2);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
